spi_cmd_regfile_slave: RTL and testbench

- Parametrised SPI slave that decodes fixed-length command frames from the host (Raspberry Pi) into a small control register file.
- Successor to the fixed 16-bit, write-only command decoder. It adds:
  - configurable frame, address and data widths, and SPI mode;
  - register readback on MISO;
  - frame-length error detection and counting.
- Sits between the chip's uio SPI pins and the datapath control inputs: calibration enable, ADC enable, channel count, etc.

---
 rtl/spi_cmd_regfile_slave.sv | 199 +++++++++++++++++++
 tb/tb_spi_cmd_regfile_slave.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_regfile_slave.sv
// SPI slave decoding fixed-length command frames into a small register file.
// Supports readback on MISO and counts malformed frames.
module spi_cmd_regfile_slave #(
    parameter int                             ADDR_WIDTH   = 8,
    parameter int                             DATA_WIDTH   = 8,
    parameter int                             FRAME_WIDTH  = 16,
    parameter int                             NUM_REGS     = 4,
    parameter logic [ADDR_WIDTH-2:0]          REG_BASE     = 'h10,
    parameter logic [NUM_REGS*DATA_WIDTH-1:0] RESET_VALUES = '0,
    parameter bit                             CPOL         = 1'b1,
    parameter bit                             CPHA         = 1'b1,
    parameter bit                             BYTE_SWAP    = 1'b1,
    parameter int                             SYNC_STAGES  = 2,
    localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                           clk_i,
    input  logic                           nreset_i,
    input  logic                           sck_i,
    input  logic                           mosi_i,
    input  logic                           ss_ni,
    output logic                           miso_o,
    output logic                           miso_oe_o,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
    output logic                           wr_strobe_o,
    output logic [IW-1:0]                  wr_index_o,
    output logic                           frame_err_o,
    output logic [7:0]                     err_count_o
);

    localparam int AW1 = ADDR_WIDTH - 1;
    localparam int CW  = $clog2(FRAME_WIDTH + 2);
    localparam logic [CW-1:0]  LP_FULL  = CW'(FRAME_WIDTH);
    localparam logic [CW-1:0]  LP_SAT   = CW'(FRAME_WIDTH + 1);
    localparam logic [AW1-1:0] LP_NREGS = AW1'(NUM_REGS);

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_CHECK} state_t;
    state_t r_state, w_state_nxt;

    logic [SYNC_STAGES-1:0]          r_sck_sync, r_mosi_sync, r_ss_sync;
    logic                            r_sck_prev, r_ss_prev;
    logic [FRAME_WIDTH-1:0]          r_rx, r_tx;
    logic [CW-1:0]                   r_cnt;
    logic                            r_miso, r_oe;
    logic [NUM_REGS*DATA_WIDTH-1:0]  r_regs;
    logic [IW-1:0]                   r_wr_idx;
    logic [7:0]                      r_err_cnt;
    logic                            r_rd_vld;
    logic [ADDR_WIDTH-1:0]           r_rd_addr;
    logic [DATA_WIDTH-1:0]           r_rd_data;

    logic w_sck, w_mosi, w_ss;
    logic w_sck_rise, w_sck_fall, w_sample, w_shift;
    logic w_ss_fall, w_ss_rise;
    logic [ADDR_WIDTH-1:0]  w_addr;
    logic [DATA_WIDTH-1:0]  w_data;
    logic [AW1-1:0]         w_off;
    logic [IW-1:0]          w_idx;
    logic                   w_hit, w_len_ok, w_wr_ok, w_rd_ok;
    logic [FRAME_WIDTH-1:0] w_tx_load;

    assign w_sck  = r_sck_sync[SYNC_STAGES-1];
    assign w_mosi = r_mosi_sync[SYNC_STAGES-1];
    assign w_ss   = r_ss_sync[SYNC_STAGES-1];

    assign w_sck_rise = w_sck & ~r_sck_prev;
    assign w_sck_fall = ~w_sck & r_sck_prev;
    assign w_sample   = (CPOL == CPHA) ? w_sck_rise : w_sck_fall;
    assign w_shift    = (CPOL == CPHA) ? w_sck_fall : w_sck_rise;
    assign w_ss_fall  = ~w_ss & r_ss_prev;
    assign w_ss_rise  = w_ss & ~r_ss_prev;

    // Field order on the wire depends on BYTE_SWAP; MSB of address is the read flag
    assign w_addr = BYTE_SWAP ? r_rx[ADDR_WIDTH-1:0]
                              : r_rx[FRAME_WIDTH-1 -: ADDR_WIDTH];
    assign w_data = BYTE_SWAP ? r_rx[FRAME_WIDTH-1 -: DATA_WIDTH]
                              : r_rx[DATA_WIDTH-1:0];
    assign w_off    = w_addr[AW1-1:0] - REG_BASE;
    assign w_hit    = (w_addr[AW1-1:0] >= REG_BASE) && (w_off < LP_NREGS);
    assign w_idx    = w_off[IW-1:0];
    assign w_len_ok = (r_cnt == LP_FULL);
    assign w_wr_ok  = w_len_ok && w_hit && !w_addr[AW1];
    assign w_rd_ok  = w_len_ok && w_hit && w_addr[AW1];

    assign w_tx_load = !r_rd_vld ? '0 :
                       BYTE_SWAP ? {r_rd_data, r_rd_addr}
                                 : {r_rd_addr, r_rd_data};

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        wr_strobe_o = 1'b0;
        frame_err_o = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_ss_fall) w_state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (w_ss_rise) w_state_nxt = ST_CHECK;
            end
            ST_CHECK: begin
                w_state_nxt = ST_IDLE;
                wr_strobe_o = w_wr_ok;
                frame_err_o = !w_len_ok;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            r_sck_sync  <= '0;
            r_mosi_sync <= '0;
            r_ss_sync   <= '0;
            r_sck_prev  <= 1'b0;
            r_ss_prev   <= 1'b0;
        end else begin
            r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], sck_i};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi_i};
            r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], ss_ni};
            r_sck_prev  <= w_sck;
            r_ss_prev   <= w_ss;
        end
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            r_rx      <= '0;
            r_tx      <= '0;
            r_cnt     <= '0;
            r_miso    <= 1'b0;
            r_oe      <= 1'b0;
            r_regs    <= RESET_VALUES;
            r_wr_idx  <= '0;
            r_err_cnt <= '0;
            r_rd_vld  <= 1'b0;
            r_rd_addr <= '0;
            r_rd_data <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_ss_fall) begin
                        r_cnt    <= '0;
                        r_oe     <= 1'b1;
                        r_rd_vld <= 1'b0;
                        // CPHA=0 drives the MSB before the first clock edge
                        if (!CPHA) begin
                            r_miso <= w_tx_load[FRAME_WIDTH-1];
                            r_tx   <= w_tx_load << 1;
                        end else begin
                            r_miso <= 1'b0;
                            r_tx   <= w_tx_load;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (w_sample) begin
                        r_rx <= {r_rx[FRAME_WIDTH-2:0], w_mosi};
                        if (r_cnt != LP_SAT) r_cnt <= r_cnt + CW'(1);
                    end
                    if (w_shift) begin
                        r_miso <= r_tx[FRAME_WIDTH-1];
                        r_tx   <= r_tx << 1;
                    end
                    if (w_ss_rise) begin
                        r_oe   <= 1'b0;
                        r_miso <= 1'b0;
                    end
                end
                ST_CHECK: begin
                    if (!w_len_ok) begin
                        if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
                    end else if (w_wr_ok) begin
                        r_regs[w_idx*DATA_WIDTH +: DATA_WIDTH] <= w_data;
                        r_wr_idx <= w_idx;
                    end else if (w_rd_ok) begin
                        r_rd_vld  <= 1'b1;
                        r_rd_addr <= w_addr;
                        r_rd_data <= r_regs[w_idx*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
                default: ;
            endcase
        end
    end

    assign miso_o      = r_miso;
    assign miso_oe_o   = r_oe;
    assign regs_o      = r_regs;
    assign wr_index_o  = r_wr_idx;
    assign err_count_o = r_err_cnt;

endmodule

// File: tb/tb_spi_cmd_regfile_slave.sv
// Directed bench for spi_cmd_regfile_slave: mode 3 swapped instance
// plus a mode 0 address-first instance.
module tb_spi_cmd_regfile_slave;

    localparam int HALF = 8;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;

    logic        sck_a = 1'b1, mosi_a = 1'b0, ss_a = 1'b1;
    logic        miso_a, oe_a, wr_a, err_a;
    logic [31:0] regs_a;
    logic [1:0]  idx_a;
    logic [7:0]  cnt_a;

    logic        sck_b = 1'b0, mosi_b = 1'b0, ss_b = 1'b1;
    logic        miso_b, oe_b, wr_b, err_b;
    logic [31:0] regs_b;
    logic [1:0]  idx_b;
    logic [7:0]  cnt_b;

    int n_chk = 0;
    int n_fail = 0;
    int wr_cnt_a = 0, err_cnt_a = 0, wr_cnt_b = 0;
    logic oe_seen = 1'b0;

    always #5 clk = ~clk;

    spi_cmd_regfile_slave u_dut_a (
        .clk_i       (clk),
        .nreset_i    (nrst),
        .sck_i       (sck_a),
        .mosi_i      (mosi_a),
        .ss_ni       (ss_a),
        .miso_o      (miso_a),
        .miso_oe_o   (oe_a),
        .regs_o      (regs_a),
        .wr_strobe_o (wr_a),
        .wr_index_o  (idx_a),
        .frame_err_o (err_a),
        .err_count_o (cnt_a)
    );

    spi_cmd_regfile_slave #(
        .CPOL      (1'b0),
        .CPHA      (1'b0),
        .BYTE_SWAP (1'b0)
    ) u_dut_b (
        .clk_i       (clk),
        .nreset_i    (nrst),
        .sck_i       (sck_b),
        .mosi_i      (mosi_b),
        .ss_ni       (ss_b),
        .miso_o      (miso_b),
        .miso_oe_o   (oe_b),
        .regs_o      (regs_b),
        .wr_strobe_o (wr_b),
        .wr_index_o  (idx_b),
        .frame_err_o (err_b),
        .err_count_o (cnt_b)
    );

    always @(negedge clk) begin
        if (wr_a) wr_cnt_a++;
        if (err_a) err_cnt_a++;
        if (wr_b) wr_cnt_b++;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Mode 3 master: drive on falling, slave samples on rising
    task automatic spi_a(input logic [15:0] tx, input int nbits,
                         input bit rst_mid, output logic [15:0] rx);
        rx = '0;
        ss_a = 1'b0;
        repeat (HALF) @(negedge clk);
        oe_seen = oe_a;
        for (int i = 0; i < nbits; i++) begin
            sck_a  = 1'b0;
            mosi_a = tx[15-i];
            repeat (HALF) @(negedge clk);
            rx = {rx[14:0], miso_a};
            sck_a = 1'b1;
            repeat (HALF) @(negedge clk);
        end
        if (rst_mid) begin
            nrst = 1'b0;
            repeat (4) @(negedge clk);
            nrst = 1'b1;
            repeat (4) @(negedge clk);
        end
        ss_a = 1'b1;
        repeat (2*HALF) @(negedge clk);
    endtask

    // Mode 0 master: data valid before rising, changes after falling
    task automatic spi_b(input logic [15:0] tx, output logic [15:0] rx);
        rx = '0;
        ss_b = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            mosi_b = tx[15-i];
            repeat (HALF) @(negedge clk);
            rx = {rx[14:0], miso_b};
            sck_b = 1'b1;
            repeat (HALF) @(negedge clk);
            sck_b = 1'b0;
        end
        repeat (HALF) @(negedge clk);
        ss_b = 1'b1;
        repeat (2*HALF) @(negedge clk);
    endtask

    initial begin
        logic [15:0] rx;
        int w0, e0;

        repeat (5) @(negedge clk);
        nrst = 1'b1;
        repeat (10) @(negedge clk);

        chk("rst_regs_a", regs_a, 32'h0);
        chk("rst_regs_b", regs_b, 32'h0);
        chk("rst_errcnt", {24'h0, cnt_a}, 32'h0);
        chk("rst_oe", {31'h0, oe_a}, 32'h0);
        chk("rst_miso", {31'h0, miso_a}, 32'h0);
        chk("rst_idx", {30'h0, idx_a}, 32'h0);
        chk("rst_pulses", wr_cnt_a + err_cnt_a, 32'h0);

        // data 0x01, addr 0x12
        w0 = wr_cnt_a;
        spi_a(16'h0112, 16, 1'b0, rx);
        chk("wr2_regs", regs_a, 32'h0001_0000);
        chk("wr2_strobes", wr_cnt_a - w0, 32'd1);
        chk("wr2_idx", {30'h0, idx_a}, 32'd2);
        chk("oe_in_frame", {31'h0, oe_seen}, 32'd1);
        chk("oe_after", {31'h0, oe_a}, 32'd0);
        chk("miso_after", {31'h0, miso_a}, 32'd0);

        w0 = wr_cnt_a;
        spi_a(16'h0713, 16, 1'b0, rx);
        spi_a(16'h0110, 16, 1'b0, rx);
        chk("wr30_regs", regs_a, 32'h0701_0001);
        chk("wr30_strobes", wr_cnt_a - w0, 32'd2);
        chk("wr30_idx", {30'h0, idx_a}, 32'd0);

        w0 = wr_cnt_a;
        e0 = err_cnt_a;
        spi_a(16'h5511, 12, 1'b0, rx);
        chk("short_regs", regs_a, 32'h0701_0001);
        chk("short_strobes", wr_cnt_a - w0, 32'd0);
        chk("short_errpulse", err_cnt_a - e0, 32'd1);
        chk("short_errcnt", {24'h0, cnt_a}, 32'd1);

        e0 = err_cnt_a;
        for (int k = 0; k < 256; k++) spi_a(16'h8000, 1, 1'b0, rx);
        chk("sat_errpulse", err_cnt_a - e0, 32'd256);
        chk("sat_errcnt", {24'h0, cnt_a}, 32'd255);

        // read request for reg3 (addr 0x93)
        w0 = wr_cnt_a;
        e0 = err_cnt_a;
        spi_a(16'h0093, 16, 1'b0, rx);
        chk("rdreq_miso", {16'h0, rx}, 32'h0);
        spi_a(16'h0000, 16, 1'b0, rx);
        chk("rd_echo", {16'h0, rx}, 32'h0793);
        spi_a(16'h0000, 16, 1'b0, rx);
        chk("rd_cleared", {16'h0, rx}, 32'h0);
        chk("rd_regs", regs_a, 32'h0701_0001);
        chk("rd_strobes", wr_cnt_a - w0, 32'd0);
        chk("rd_errs", err_cnt_a - e0, 32'd0);

        // address 0x20 is outside the register window
        w0 = wr_cnt_a;
        e0 = err_cnt_a;
        spi_a(16'hAA20, 16, 1'b0, rx);
        chk("oor_regs", regs_a, 32'h0701_0001);
        chk("oor_strobes", wr_cnt_a - w0, 32'd0);
        chk("oor_errs", err_cnt_a - e0, 32'd0);

        w0 = wr_cnt_a;
        spi_a(16'h5511, 8, 1'b1, rx);
        chk("rstmid_regs", regs_a, 32'h0);
        chk("rstmid_strobes", wr_cnt_a - w0, 32'd0);
        chk("rstmid_errcnt", {24'h0, cnt_a}, 32'd0);
        chk("rstmid_oe", {31'h0, oe_a}, 32'd0);

        w0 = wr_cnt_a;
        spi_a(16'h0111, 16, 1'b0, rx);
        chk("wr1_regs", regs_a, 32'h0000_0100);
        chk("wr1_strobes", wr_cnt_a - w0, 32'd1);
        chk("wr1_idx", {30'h0, idx_a}, 32'd1);

        w0 = wr_cnt_b;
        spi_b(16'h12AB, rx);
        chk("m0_regs", regs_b, 32'h00AB_0000);
        chk("m0_strobes", wr_cnt_b - w0, 32'd1);
        chk("m0_idx", {30'h0, idx_b}, 32'd2);
        chk("m0_errcnt", {24'h0, cnt_b}, 32'd0);
        chk("m0_miso", {16'h0, rx}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
